cfg_write_arbiter: RTL



---
 rtl/cfg_write_arbiter_if.sv | 26 ++
 rtl/cfg_write_arbiter.sv | 116 +++++++++++
 2 files changed

// File: rtl/cfg_write_arbiter_if.sv
// rtl/cfg_write_arbiter_if.sv - write request/acknowledge bus shared by the SPI decoder and the sequencer
interface cfg_write_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic              req_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] data_a;
  logic              ack_a;
  logic              err_a;
  logic              req_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] data_b;
  logic              ack_b;
  logic              err_b;

  modport master (
    output req_a, addr_a, data_a, req_b, addr_b, data_b,
    input  ack_a, err_a, ack_b, err_b
  );

  modport slave (
    input  req_a, addr_a, data_a, req_b, addr_b, data_b,
    output ack_a, err_a, ack_b, err_b
  );
endinterface

// File: rtl/cfg_write_arbiter.sv
// rtl/cfg_write_arbiter.sv - round-robin two-port arbiter owning the output-enable/PWM register bank
module cfg_write_arbiter #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int MAX_ADDRESS = 4
) (
  input  logic                clk,
  input  logic                rst,
  cfg_write_arbiter_if.slave  bus,
  output logic [DATA_W-1:0]   en_reg_out_7_0,
  output logic [DATA_W-1:0]   en_reg_out_15_8,
  output logic [DATA_W-1:0]   en_reg_pwm_7_0,
  output logic [DATA_W-1:0]   en_reg_pwm_15_8,
  output logic [DATA_W-1:0]   pwm_duty_cycle,
  output logic                busy,
  output logic [7:0]          write_count
);

  localparam int NUM_REGS = MAX_ADDRESS + 1;

  typedef enum logic [1:0] {IDLE, COMMIT, RELEASE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              grant_b;
  logic              grant_b_nxt;
  logic              last_grant_b;
  logic              load;
  logic              addr_ok;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] regs [NUM_REGS];

  assign addr_ok = (addr_q <= ADDR_W'(MAX_ADDRESS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
    end
  end

  always_comb begin
    state_nxt   = state;
    grant_b_nxt = grant_b;
    load        = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_a || bus.req_b) begin
          load      = 1'b1;
          state_nxt = COMMIT;
          // On a tie the port that was not served last wins
          if (bus.req_a && bus.req_b)
            grant_b_nxt = ~last_grant_b;
          else
            grant_b_nxt = bus.req_b;
        end
      end
      COMMIT:  state_nxt = RELEASE;
      RELEASE: begin
        if (!(grant_b ? bus.req_b : bus.req_a))
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_b      <= 1'b0;
      last_grant_b <= 1'b1;
      addr_q       <= '0;
      data_q       <= '0;
      bus.ack_a    <= 1'b0;
      bus.ack_b    <= 1'b0;
      bus.err_a    <= 1'b0;
      bus.err_b    <= 1'b0;
      write_count  <= 8'd0;
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else begin
      bus.ack_a <= 1'b0;
      bus.ack_b <= 1'b0;
      bus.err_a <= 1'b0;
      bus.err_b <= 1'b0;
      grant_b   <= grant_b_nxt;
      if (load) begin
        addr_q <= grant_b_nxt ? bus.addr_b : bus.addr_a;
        data_q <= grant_b_nxt ? bus.data_b : bus.data_a;
      end
      if (state == COMMIT) begin
        last_grant_b <= grant_b;
        bus.ack_a    <= ~grant_b;
        bus.ack_b    <= grant_b;
        bus.err_a    <= ~grant_b & ~addr_ok;
        bus.err_b    <= grant_b & ~addr_ok;
        if (addr_ok) begin
          write_count <= write_count + 8'd1;
          for (int i = 0; i < NUM_REGS; i++)
            if (addr_q == ADDR_W'(i))
              regs[i] <= data_q;
        end
      end
    end
  end

  assign en_reg_out_7_0  = regs[0];
  assign en_reg_out_15_8 = regs[1];
  assign en_reg_pwm_7_0  = regs[2];
  assign en_reg_pwm_15_8 = regs[3];
  assign pwm_duty_cycle  = regs[4];

endmodule
